e_mdu: RTL

E-stage multiply/divide unit for the 5-stage MIPS pipeline. Consumes the rs/rt operands and decoded MD op latched by the D/E pipeline register, and owns the HI/LO architectural registers.
- Models fixed multi-cycle latency: asserts busy so the hazard unit stalls D while an MD-class instruction is pending.
- Supplies the mfhi/mflo read value to the E-stage result mux.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_divider.sv | 33 +++
 rtl/e_mdu.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MD op encoding and classification helpers
package mdu_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8
  } md_op_t;

  // Ops that launch a multi-cycle computation
  function automatic logic is_md_start(input md_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  // Any op that touches the MD unit or HI/LO
  function automatic logic is_md(input md_op_t op);
    return (op != NONE) && (op <= MTLO);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - combinational signed/unsigned 32-bit quotient and remainder
module mdu_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div0
);

  logic        neg_q;
  logic        neg_r;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Divide magnitudes, then restore signs: quotient truncates toward zero and
  // the remainder follows the dividend. INT_MIN / -1 falls out as 0x80000000
  // because negating 0x80000000 wraps back to itself.
  always_comb begin
    neg_q     = is_signed & (dividend[31] ^ divisor[31]);
    neg_r     = is_signed & dividend[31];
    a_mag     = neg_r ? (32'd0 - dividend) : dividend;
    b_mag     = (is_signed & divisor[31]) ? (32'd0 - divisor) : divisor;
    div0      = (divisor == 32'd0);
    q_mag     = div0 ? 32'd0 : (a_mag / b_mag);
    r_mag     = div0 ? 32'd0 : (a_mag % b_mag);
    quotient  = neg_q ? (32'd0 - q_mag) : q_mag;
    remainder = neg_r ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit owning HI/LO with fixed latency
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  md_op_t      op_e;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_zero;

  assign op_e   = md_op_t'(op);
  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  mdu_divider u_div (
    .dividend  (rs_data),
    .divisor   (rt_data),
    .is_signed (op_e == DIV),
    .quotient  (div_quot),
    .remainder (div_rem),
    .div0      (div_zero)
  );

  // Next-state: launch in IDLE, count down in BUSY, commit on the last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start && is_md_start(op_e)) begin
          if ((op_e == MULT) || (op_e == MULTU)) begin
            {phi_d, plo_d} = (op_e == MULT) ? prod_s : prod_u;
            div0_d         = 1'b0;
            cnt_d          = CW'(MULT_CYCLES);
          end else begin
            plo_d  = div_quot;
            phi_d  = div_rem;
            div0_d = div_zero;
            cnt_d  = CW'(DIV_CYCLES);
          end
          state_d = BUSY;
          busy_d  = 1'b1;
        end else if (op_e == MTHI) begin
          hi_d = rs_data;
        end else if (op_e == MTLO) begin
          lo_d = rs_data;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (!div0_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset that also discards any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
    end
  end

  // Read mux for mfhi/mflo feeding the E-stage result select
  always_comb begin
    rdata = 32'd0;
    if (op_e == MFHI) rdata = hi_q;
    else if (op_e == MFLO) rdata = lo_q;
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
